act_lanes: RTL and testbench
============================

// Module: act_lanes
// PURPOSE
//  Parametrised multi-lane activation unit; successor to the packed 2x16 ReLU stage.
//  Applies one of four per-beat modes (bypass, ReLU, clipped ReLU, leaky ReLU) to LANES signed lanes.
//  Uses a 2-stage elastic pipeline with valid/ready backpressure.
//  Sits between the matmul accumulator output and the writeback/requant path of the transformer datapath.
// PARAMETERS
//  LANES   2   number of independent signed lanes packed in one beat (>=1)
//  LWIDTH  16  bits per lane, two's complement (>=4)
//  SHW     4   width of leaky shift amount; must satisfy 2**SHW >= LWIDTH
//  CWIDTH  16  width of zero-lane statistics counter (ACT_ZCNT_EN only)
//  (localparam DWIDTH = LANES*LWIDTH)
// PORTS
//  clk      in   1       clock, rising edge
//  arst_n   in   1       asynchronous active-low reset
//  i_valid  in   1       input beat valid
//  o_ready  out  1       unit can accept input this cycle
//  i_data   in   DWIDTH  lanes; lane k = i_data[k*LWIDTH +: LWIDTH], lane LANES-1 in MSBs
//  i_mode   in   2       0 bypass, 1 ReLU, 2 clipped ReLU, 3 leaky ReLU; sampled with the beat
//  i_clip   in   LWIDTH-1 unsigned positive clip ceiling for mode 2; sampled with the beat
//  i_shift  in   SHW     arithmetic right-shift for negatives in mode 3; sampled with the beat
//  o_valid  out  1       output beat valid
//  i_ready  in   1       downstream accepts output
//  o_data   out  DWIDTH  activated lanes, same packing as i_data
//  i_zclr   in   1       sync clear of o_zcnt (ACT_ZCNT_EN only)
//  o_zcnt   out  CWIDTH  count of lanes forced to zero (ACT_ZCNT_EN only)
// BEHAVIOUR
//  - Reset (async assert, sync release): all stage valids = 0; o_valid = 0; o_data = 0; o_zcnt = 0.
//  - S1 registers {data, mode, clip, shift}; S2 registers the computed result. S2 drives o_valid/o_data.
//  - Advance rules:
//    - s2_go = !v2 || i_ready.
//    - s1_go = !v1 || s2_go.
//    - o_ready = s1_go (combinational from i_ready; no skid).
//  - Input handshake when i_valid && o_ready. Output handshake when o_valid && i_ready.
//  - Latency: 2 cycles from input handshake to o_valid when unstalled. Throughput: 1 beat/cycle.
//  - Stall: while o_valid && !i_ready, o_data/o_valid hold stable. S1 holds if occupied. No beat is lost or duplicated.
//  - i_valid is allowed to drop without handshake. i_data/i_mode/i_clip/i_shift matter only on handshake cycles.
//  - Per-lane compute on x (signed LWIDTH):
//    - mode 0: y = x.
//    - mode 1: y = x<0 ? 0 : x.
//    - mode 2: y = x<0 ? 0 : (x > clip ? clip : x), where clip is zero-extended to LWIDTH.
//    - mode 3: y = x<0 ? (x >>> shift) : x. shift=0 gives identity; shift>=LWIDTH gives -1 for negative x.
//  - No rounding; the result always fits LWIDTH.
//  - Lanes are fully independent; no carry or sign interaction across lanes.
//  - Simultaneous input and output handshakes in a full pipe: both proceed, occupancy unchanged.
//  - Reset mid-operation: in-flight beats are discarded. The first post-reset beat follows normal latency.
// CONFIGURATION
//  - Macro ACT_ZCNT_EN, when defined, enables the zero-lane statistics counter:
//    - o_zcnt += number of lanes whose x<0 in mode 1 or 2, counted at S1->S2 transfer.
//    - o_zcnt saturates at 2**CWIDTH-1.
//    - i_zclr forces o_zcnt to 0 on the next edge; clear wins over a simultaneous increment.
//  - Without the macro: i_zclr is ignored, o_zcnt is tied to 0, and no counter flops are inferred.
//  - The datapath is identical in both builds.
// TESTING (LANES=2, LWIDTH=16, SHW=4)
//  - Mode 1, i_data=32'h8001_7FFF, i_ready=1 -> o_data=32'h0000_7FFF two cycles later; zcnt +1 if enabled.
//  - Mode 2, clip=15'h0100, i_data=32'h0200_00FF -> o_data=32'h0100_00FF. Also i_data=32'hFFFF_0100 -> 32'h0000_0100.
//  - Mode 3, shift=2, i_data=32'h8000_FFF8 -> o_data=32'hE000_FFFE. Shift=0 -> data unchanged. Mode 0 -> unchanged.
//  - Backpressure:
//    - Stream 8 beats with mixed modes; i_ready low for 3 cycles mid-stream.
//    - Required: o_ready drops with both stages full; o_data held stable; all 8 beats arrive in order with correct values.
//  - Reset mid-stream:
//    - Assert arst_n=0 with 2 beats in flight.
//    - Required: o_valid=0 and o_data=0 immediately; next beat emerges exactly 2 cycles after its handshake.
//  - ACT_ZCNT_EN, CWIDTH=2:
//    - 5 beats of all-negative lanes in mode 1 -> o_zcnt saturates at 3.
//    - i_zclr on the same cycle as an increment -> o_zcnt=0.

Source files
------------

// File: rtl/act_lanes_if.sv
// Beat-level handshake bundle for act_lanes: input beat with per-beat mode fields, output beat,
// and the zero-lane statistics side channel. The slave modport is the activation unit's view.
interface act_lanes_if #(
   parameter int LANES  = 2,
   parameter int LWIDTH = 16,
   parameter int SHW    = 4,
   parameter int CWIDTH = 16
);
   localparam int DWIDTH = LANES * LWIDTH;

   logic                i_valid;
   logic                o_ready;
   logic [DWIDTH-1:0]   i_data;
   logic [1:0]          i_mode;
   logic [LWIDTH-2:0]   i_clip;
   logic [SHW-1:0]      i_shift;
   logic                o_valid;
   logic                i_ready;
   logic [DWIDTH-1:0]   o_data;
   logic                i_zclr;
   logic [CWIDTH-1:0]   o_zcnt;

   modport slave (
      input  i_valid, i_data, i_mode, i_clip, i_shift, i_ready, i_zclr,
      output o_ready, o_valid, o_data, o_zcnt
   );

   modport master (
      output i_valid, i_data, i_mode, i_clip, i_shift, i_ready, i_zclr,
      input  o_ready, o_valid, o_data, o_zcnt
   );
endinterface

// File: rtl/act_lanes.sv
// Multi-lane activation (bypass/ReLU/clipped ReLU/leaky ReLU); latency 2 cycles, 1 beat/cycle.
// Backpressure: o_ready is combinational from i_ready, stalled stages hold; ACT_ZCNT_EN adds o_zcnt.
module act_lanes #(
   parameter int LANES  = 2,
   parameter int LWIDTH = 16,
   parameter int SHW    = 4,
   parameter int CWIDTH = 16
) (
   input  logic         clk,
   input  logic         arst_n,
   act_lanes_if.slave   bus
);
   localparam int DWIDTH = LANES * LWIDTH;

   typedef enum logic [1:0] {
      MODE_BYP   = 2'd0,
      MODE_RELU  = 2'd1,
      MODE_CLIP  = 2'd2,
      MODE_LEAKY = 2'd3
   } mode_e;

   typedef struct packed {
      logic [DWIDTH-1:0] data;
      mode_e             mode;
      logic [LWIDTH-2:0] clip;
      logic [SHW-1:0]    shift;
   } beat_t;

   logic              v1_q;
   logic              v2_q;
   beat_t             s1_q;
   beat_t             s1_nxt;
   logic [DWIDTH-1:0] s2_q;
   logic [DWIDTH-1:0] s2_nxt;
   logic              s1_go;
   logic              s2_go;

   // Clip is an unsigned ceiling, so it is always compared as a non-negative lane value.
   function automatic logic [LWIDTH-1:0] act_lane(
      input logic [LWIDTH-1:0] x_raw,
      input mode_e             mode,
      input logic [LWIDTH-2:0] clip,
      input logic [SHW-1:0]    shift
   );
      logic signed [LWIDTH-1:0] x;
      logic signed [LWIDTH-1:0] c;
      logic                     neg;
      logic [LWIDTH-1:0]        y;
      x   = $signed(x_raw);
      c   = $signed({1'b0, clip});
      neg = x_raw[LWIDTH-1];
      y   = x_raw;
      case (mode)
         MODE_RELU: begin
            if (neg) y = '0;
         end
         MODE_CLIP: begin
            if (neg)        y = '0;
            else if (x > c) y = c;
         end
         MODE_LEAKY: begin
            if (neg) y = x >>> shift;
         end
         default: y = x_raw;
      endcase
      return y;
   endfunction

   assign s2_go       = !v2_q || bus.i_ready;
   assign s1_go       = !v1_q || s2_go;
   assign bus.o_ready = s1_go;
   assign bus.o_valid = v2_q;
   assign bus.o_data  = s2_q;

   always_comb begin
      s1_nxt       = '0;
      s1_nxt.data  = bus.i_data;
      s1_nxt.mode  = mode_e'(bus.i_mode);
      s1_nxt.clip  = bus.i_clip;
      s1_nxt.shift = bus.i_shift;
   end

   always_comb begin
      s2_nxt = '0;
      for (int k = 0; k < LANES; k++) begin
         s2_nxt[k*LWIDTH +: LWIDTH] = act_lane(s1_q.data[k*LWIDTH +: LWIDTH],
                                               s1_q.mode, s1_q.clip, s1_q.shift);
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         v1_q <= 1'b0;
         s1_q <= '0;
      end else if (s1_go) begin
         v1_q <= bus.i_valid;
         if (bus.i_valid) s1_q <= s1_nxt;
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         v2_q <= 1'b0;
         s2_q <= '0;
      end else if (s2_go) begin
         v2_q <= v1_q;
         if (v1_q) s2_q <= s2_nxt;
      end
   end

`ifdef ACT_ZCNT_EN
   localparam int ZW = CWIDTH + $clog2(LANES + 1) + 1;

   logic [CWIDTH-1:0] zcnt_q;
   logic [ZW-1:0]     zlanes;
   logic [ZW-1:0]     zsum;

   // Zeroed lanes are counted as the beat moves S1->S2 so stalls never double count.
   always_comb begin
      zlanes = '0;
      if (v1_q && s2_go && (s1_q.mode == MODE_RELU || s1_q.mode == MODE_CLIP)) begin
         for (int k = 0; k < LANES; k++) begin
            zlanes = zlanes + ZW'(s1_q.data[k*LWIDTH + LWIDTH - 1]);
         end
      end
      zsum = ZW'(zcnt_q) + zlanes;
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         zcnt_q <= '0;
      end else if (bus.i_zclr) begin
         zcnt_q <= '0;
      end else if (zsum > ZW'({CWIDTH{1'b1}})) begin
         zcnt_q <= '1;
      end else begin
         zcnt_q <= zsum[CWIDTH-1:0];
      end
   end

   assign bus.o_zcnt = zcnt_q;
`else
   logic unused_zclr;
   assign unused_zclr = bus.i_zclr;
   assign bus.o_zcnt  = '0;
`endif

`ifndef SYNTHESIS
   a_stall_hold: assert property (@(posedge clk) disable iff (!arst_n)
      (bus.o_valid && !bus.i_ready) |=> (bus.o_valid && $stable(bus.o_data)));
`endif

endmodule

// File: tb/tb_act_lanes.sv
// Directed bench for act_lanes (LANES=2, LWIDTH=16, SHW=4); CWIDTH=2 when ACT_ZCNT_EN is defined.
module tb_act_lanes;
`ifdef ACT_ZCNT_EN
   localparam int CW = 2;
`else
   localparam int CW = 16;
`endif

   logic clk;
   logic arst_n;
   int   checks = 0;
   int   errors = 0;
   int   zmodel = 0;

   act_lanes_if #(.LANES(2), .LWIDTH(16), .SHW(4), .CWIDTH(CW)) bus ();

   act_lanes #(.LANES(2), .LWIDTH(16), .SHW(4), .CWIDTH(CW)) dut (
      .clk    (clk),
      .arst_n (arst_n),
      .bus    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]  mode;
      logic [14:0] clip;
      logic [3:0]  shift;
      logic [31:0] data;
      logic [31:0] exp;
   } vec_t;

   vec_t bp_vec [8];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic int neg_lanes(input logic [1:0] m, input logic [31:0] d);
      int n;
      n = 0;
      if (m == 2'd1 || m == 2'd2) n = int'(d[31]) + int'(d[15]);
      return n;
   endfunction

   function automatic int zadd(input int z, input int n);
      int lim;
      lim = (1 << CW) - 1;
      return (z + n > lim) ? lim : z + n;
   endfunction

   function automatic logic [31:0] zexp();
`ifdef ACT_ZCNT_EN
      return 32'(zmodel);
`else
      return 32'd0;
`endif
   endfunction

   task automatic set_beat(input logic [1:0] m, input logic [14:0] cl, input logic [3:0] sh,
                           input logic [31:0] d);
      bus.i_valid = 1'b1;
      bus.i_mode  = m;
      bus.i_clip  = cl;
      bus.i_shift = sh;
      bus.i_data  = d;
   endtask

   // Called at a negedge with an empty pipe and i_ready high.
   task automatic run_one(input string tag, input logic [1:0] m, input logic [14:0] cl,
                          input logic [3:0] sh, input logic [31:0] d, input logic [31:0] e);
      set_beat(m, cl, sh, d);
      #1 chk({tag, "_ordy"}, 32'(bus.o_ready), 32'd1);
      @(negedge clk);
      bus.i_valid = 1'b0;
      zmodel = zadd(zmodel, neg_lanes(m, d));
      #1 chk({tag, "_lat1"}, 32'(bus.o_valid), 32'd0);
      @(negedge clk);
      #1 chk({tag, "_vld"}, 32'(bus.o_valid), 32'd1);
      chk({tag, "_dat"}, bus.o_data, e);
      @(negedge clk);
   endtask

   initial begin
      bp_vec[0] = '{2'd0, 15'h0000, 4'd0, 32'h1234_8765, 32'h1234_8765};
      bp_vec[1] = '{2'd1, 15'h0000, 4'd0, 32'hFFFF_0001, 32'h0000_0001};
      bp_vec[2] = '{2'd2, 15'h0010, 4'd0, 32'h0011_800F, 32'h0010_0000};
      bp_vec[3] = '{2'd3, 15'h0000, 4'd1, 32'hFFFE_0004, 32'hFFFF_0004};
      bp_vec[4] = '{2'd1, 15'h0000, 4'd0, 32'h7FFF_8000, 32'h7FFF_0000};
      bp_vec[5] = '{2'd3, 15'h0000, 4'd4, 32'hF000_8000, 32'hFF00_F800};
      bp_vec[6] = '{2'd2, 15'h7FFF, 4'd0, 32'h7FFF_0000, 32'h7FFF_0000};
      bp_vec[7] = '{2'd0, 15'h0000, 4'd0, 32'h0000_FFFF, 32'h0000_FFFF};

      arst_n      = 1'b0;
      bus.i_valid = 1'b0;
      bus.i_ready = 1'b1;
      bus.i_data  = '0;
      bus.i_mode  = '0;
      bus.i_clip  = '0;
      bus.i_shift = '0;
      bus.i_zclr  = 1'b0;
      repeat (2) @(negedge clk);
      #1 chk("rst_ovld", 32'(bus.o_valid), 32'd0);
      chk("rst_odat", bus.o_data, 32'd0);
      chk("rst_zcnt", 32'(bus.o_zcnt), 32'd0);
      @(negedge clk);
      arst_n = 1'b1;
      @(negedge clk);

      run_one("relu",     2'd1, 15'h0000, 4'd0,  32'h8001_7FFF, 32'h0000_7FFF);
      run_one("clip_a",   2'd2, 15'h0100, 4'd0,  32'h0200_00FF, 32'h0100_00FF);
      run_one("clip_b",   2'd2, 15'h0100, 4'd0,  32'hFFFF_0100, 32'h0000_0100);
      run_one("leaky2",   2'd3, 15'h0000, 4'd2,  32'h8000_FFF8, 32'hE000_FFFE);
      run_one("leaky0",   2'd3, 15'h0000, 4'd0,  32'h8000_FFF8, 32'h8000_FFF8);
      run_one("leaky15",  2'd3, 15'h0000, 4'd15, 32'h8000_0005, 32'hFFFF_0005);
      run_one("bypass",   2'd0, 15'h0100, 4'd2,  32'h8001_FFFF, 32'h8001_FFFF);
      chk("zcnt_dir", 32'(bus.o_zcnt), zexp());

      // Backpressure stream: i_ready low for cycles 4..6.
      begin
         int sent = 0, got = 0, c = 0;
         logic [31:0] held = '0;
         logic hold_v = 1'b0, saw_low = 1'b0;
         while (got < 8 && c < 60) begin
            bus.i_ready = !(c >= 4 && c < 7);
            if (sent < 8) set_beat(bp_vec[sent].mode, bp_vec[sent].clip,
                                   bp_vec[sent].shift, bp_vec[sent].data);
            else bus.i_valid = 1'b0;
            #1;
            if (hold_v) begin
               chk("bp_hold_vld", 32'(bus.o_valid), 32'd1);
               chk("bp_hold_dat", bus.o_data, held);
            end
            hold_v = bus.o_valid && !bus.i_ready;
            held   = bus.o_data;
            if (hold_v && !bus.o_ready) saw_low = 1'b1;
            if (bus.o_valid && bus.i_ready) begin
               chk("bp_data", bus.o_data, bp_vec[got].exp);
               got++;
            end
            if (bus.i_valid && bus.o_ready) begin
               zmodel = zadd(zmodel, neg_lanes(bp_vec[sent].mode, bp_vec[sent].data));
               sent++;
            end
            @(negedge clk);
            c++;
         end
         bus.i_valid = 1'b0;
         bus.i_ready = 1'b1;
         chk("bp_count", 32'(got), 32'd8);
         chk("bp_ordy_low", 32'(saw_low), 32'd1);
      end
      @(negedge clk);
      #1 chk("zcnt_bp", 32'(bus.o_zcnt), zexp());

      // Reset with two beats in flight.
      @(negedge clk);
      set_beat(2'd0, 15'h0000, 4'd0, 32'h1111_2222);
      @(negedge clk);
      set_beat(2'd0, 15'h0000, 4'd0, 32'h3333_4444);
      @(negedge clk);
      bus.i_valid = 1'b0;
      #1 chk("pre_rst_vld", 32'(bus.o_valid), 32'd1);
      arst_n = 1'b0;
      #1 chk("mid_rst_vld", 32'(bus.o_valid), 32'd0);
      chk("mid_rst_dat", bus.o_data, 32'd0);
      chk("mid_rst_zcnt", 32'(bus.o_zcnt), 32'd0);
      zmodel = 0;
      @(negedge clk);
      arst_n = 1'b1;
      @(negedge clk);
      #1 chk("post_rst_idle", 32'(bus.o_valid), 32'd0);
      run_one("post_rst", 2'd1, 15'h0000, 4'd0, 32'h8001_7FFF, 32'h0000_7FFF);

`ifdef ACT_ZCNT_EN
      bus.i_zclr = 1'b1;
      @(negedge clk);
      bus.i_zclr = 1'b0;
      #1 chk("zclr", 32'(bus.o_zcnt), 32'd0);
      for (int i = 0; i < 5; i++) begin
         set_beat(2'd1, 15'h0000, 4'd0, 32'hFFFF_FFFF);
         @(negedge clk);
      end
      bus.i_valid = 1'b0;
      repeat (3) @(negedge clk);
      #1 chk("zsat", 32'(bus.o_zcnt), 32'd3);
      set_beat(2'd1, 15'h0000, 4'd0, 32'hFFFF_FFFF);
      @(negedge clk);
      bus.i_valid = 1'b0;
      bus.i_zclr  = 1'b1;
      @(negedge clk);
      bus.i_zclr = 1'b0;
      #1 chk("zclr_win", 32'(bus.o_zcnt), 32'd0);
      repeat (2) @(negedge clk);
      #1 chk("zclr_hold", 32'(bus.o_zcnt), 32'd0);
`else
      bus.i_zclr = 1'b1;
      @(negedge clk);
      bus.i_zclr = 1'b0;
      #1 chk("zcnt_tied", 32'(bus.o_zcnt), 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "bench timeout");
   end
endmodule
